if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32, PC and instruction width.
REQ-002 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 STALL  input  1  decode side cannot accept an instruction this cycle.
REQ-006 REDIRECT  input  1  taken branch/jump; flush fetch path and restart at REDIRECT_PC.
REQ-007 REDIRECT_PC  input  WIDTH  redirect target address.
REQ-008 IMEM_REQ  output  1  fetch request valid.
REQ-009 IMEM_ADDR  output  WIDTH  fetch address; equals PC while IMEM_REQ=1.
REQ-010 IMEM_READY  input  1  memory accepts request when IMEM_REQ=1 and IMEM_READY=1.
REQ-011 IMEM_RVALID  input  1  response valid, one cycle per accepted request.
REQ-012 IMEM_RDATA  input  WIDTH  response instruction word.
REQ-013 PC_OUT  output  WIDTH  PC of delivered instruction (drives IF/ID PC_IN).
REQ-014 INSTRUCTION_OUT  output  WIDTH  delivered instruction (drives IF/ID INSTRUCTION_IN).
REQ-015 VALID_OUT  output  1  one-cycle pulse per delivered instruction.
REQ-016 FLUSH_OUT  output  1  flush to IF/ID register.

Function
REQ-017 States: FETCH, WAIT, HOLD, DROP; at most one outstanding memory request.
REQ-018 IMEM_REQ SHALL be 1 only when state=FETCH and REDIRECT=0 and rst=0; IMEM_ADDR=PC at all times.
REQ-019 FETCH: on IMEM_REQ and IMEM_READY, latch REQ_PC<=PC, go WAIT; otherwise stay, PC and IMEM_ADDR stable.
REQ-020 WAIT, IMEM_RVALID=1, STALL=0: next cycle PC_OUT=REQ_PC, INSTRUCTION_OUT=IMEM_RDATA, VALID_OUT=1; PC<=REQ_PC+4; go FETCH.
REQ-021 WAIT, IMEM_RVALID=1, STALL=1: capture IMEM_RDATA and REQ_PC in one-entry buffer, VALID_OUT=0, go HOLD.
REQ-022 HOLD: while STALL=1, hold buffer, no request; when STALL=0, next cycle deliver buffer (VALID_OUT=1), PC<=buffered PC+4, go FETCH.
REQ-023 VALID_OUT SHALL be 0 in every cycle not immediately following a delivery; PC_OUT/INSTRUCTION_OUT hold the last delivered values between deliveries.
REQ-024 PC increment SHALL be modulo 2^WIDTH (32'hFFFFFFFC+4 = 32'h00000000).
REQ-025 REDIRECT has priority over all but rst: PC<=REDIRECT_PC, buffer discarded, FLUSH_OUT=REDIRECT combinationally in the same cycle, next cycle PC_OUT=0, INSTRUCTION_OUT=0, VALID_OUT=0.
REQ-026 REDIRECT in FETCH or HOLD: go FETCH.
REQ-027 REDIRECT in WAIT with IMEM_RVALID=1 same cycle: response discarded, go FETCH.
REQ-028 REDIRECT in WAIT with IMEM_RVALID=0: go DROP.
REQ-029 DROP: no request; on IMEM_RVALID discard data, go FETCH; further REDIRECT in DROP updates PC, stays DROP until response.
REQ-030 STALL in FETCH SHALL NOT block requesting (prefetch into buffer permitted).

Reset
REQ-031 When rst=1 at a rising edge: PC<=RESET_PC, state<=FETCH, buffer cleared, PC_OUT=0, INSTRUCTION_OUT=0, VALID_OUT=0; IMEM_REQ=0 and FLUSH_OUT=0 while rst=1.
REQ-032 Reset mid-operation (any state) SHALL abandon the outstanding request; instruction memory shares rst and drops it likewise.

Verification
REQ-033 rst 1->0, IMEM_READY=1, RVALID one cycle after accept with RDATA=32'h00000013 -> VALID_OUT pulse, PC_OUT=0, INSTRUCTION_OUT=32'h00000013; next IMEM_ADDR=32'h4.
REQ-034 STALL=1 when RVALID for addr 32'h8 with RDATA=32'hAAAAAAAA -> VALID_OUT=0, IMEM_REQ=0 in HOLD; STALL->0 -> next cycle VALID_OUT=1, PC_OUT=32'h8, INSTRUCTION_OUT=32'hAAAAAAAA, then IMEM_ADDR=32'hC.
REQ-035 REDIRECT=1, REDIRECT_PC=32'h100 in WAIT, RVALID 2 cycles later with 32'hBBBBBBBB -> FLUSH_OUT=1 same cycle, outputs cleared, 32'hBBBBBBBB never delivered, next IMEM_ADDR=32'h100.
REQ-036 REDIRECT and RVALID same cycle, REDIRECT_PC=32'h40 -> no VALID_OUT, next IMEM_REQ at 32'h40.
REQ-037 REDIRECT_PC=32'hFFFFFFFC, response delivered -> PC_OUT=32'hFFFFFFFC, next IMEM_ADDR=32'h00000000.
REQ-038 IMEM_READY=0 for 5 cycles -> IMEM_REQ=1, IMEM_ADDR constant, VALID_OUT=0 throughout.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues one outstanding instruction-memory request
// at a time, delivers responses to decode, buffers one response under stall,
// and flushes/restarts on redirect.
module if_fetch_unit #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             STALL,
  input  logic             REDIRECT,
  input  logic [WIDTH-1:0] REDIRECT_PC,
  output logic             IMEM_REQ,
  output logic [WIDTH-1:0] IMEM_ADDR,
  input  logic             IMEM_READY,
  input  logic             IMEM_RVALID,
  input  logic [WIDTH-1:0] IMEM_RDATA,
  output logic [WIDTH-1:0] PC_OUT,
  output logic [WIDTH-1:0] INSTRUCTION_OUT,
  output logic             VALID_OUT,
  output logic             FLUSH_OUT
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // ready to issue a request at pc_q
    S_WAIT  = 2'd1,  // request accepted, waiting for its response
    S_HOLD  = 2'd2,  // response captured in the buffer while decode stalls
    S_DROP  = 2'd3   // response still owed but it belongs to a flushed path
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [WIDTH-1:0] buf_data_q, buf_data_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic [WIDTH-1:0] instr_out_q, instr_out_d;
  logic             valid_out_q, valid_out_d;

  // A redirect in the same cycle suppresses the request so the old path
  // never gets a second outstanding access.
  assign IMEM_REQ        = (state_q == S_FETCH) && !REDIRECT && !rst;
  assign IMEM_ADDR       = pc_q;
  assign FLUSH_OUT       = REDIRECT && !rst;
  assign PC_OUT          = pc_out_q;
  assign INSTRUCTION_OUT = instr_out_q;
  assign VALID_OUT       = valid_out_q;

  // Next-state and next-output computation; redirect overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_data_d  = buf_data_q;
    pc_out_d    = pc_out_q;
    instr_out_d = instr_out_q;
    valid_out_d = 1'b0;

    if (REDIRECT) begin
      pc_d        = REDIRECT_PC;
      buf_pc_d    = '0;
      buf_data_d  = '0;
      pc_out_d    = '0;
      instr_out_d = '0;
      case (state_q)
        // The pending response is discarded; if it is not here yet we must
        // wait it out in DROP so it cannot be mistaken for the new path.
        S_WAIT, S_DROP: state_d = IMEM_RVALID ? S_FETCH : S_DROP;
        default:        state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (IMEM_REQ && IMEM_READY) begin
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (IMEM_RVALID) begin
            if (STALL) begin
              buf_pc_d   = req_pc_q;
              buf_data_d = IMEM_RDATA;
              state_d    = S_HOLD;
            end else begin
              pc_out_d    = req_pc_q;
              instr_out_d = IMEM_RDATA;
              valid_out_d = 1'b1;
              pc_d        = req_pc_q + PC_STEP;
              state_d     = S_FETCH;
            end
          end
        end
        S_HOLD: begin
          if (!STALL) begin
            pc_out_d    = buf_pc_q;
            instr_out_d = buf_data_q;
            valid_out_d = 1'b1;
            pc_d        = buf_pc_q + PC_STEP;
            state_d     = S_FETCH;
          end
        end
        S_DROP: begin
          if (IMEM_RVALID) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      buf_pc_q    <= '0;
      buf_data_q  <= '0;
      pc_out_q    <= '0;
      instr_out_q <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_data_q  <= buf_data_d;
      pc_out_q    <= pc_out_d;
      instr_out_q <= instr_out_d;
      valid_out_q <= valid_out_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed stimulus with literal checks, plus a
// transaction-level model (outstanding request / held response occupancy)
// compared against the DUT on every cycle.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic [31:0] PC_OUT;
  logic [31:0] INSTRUCTION_OUT;
  logic        VALID_OUT;
  logic        FLUSH_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .STALL           (STALL),
    .REDIRECT        (REDIRECT),
    .REDIRECT_PC     (REDIRECT_PC),
    .IMEM_REQ        (IMEM_REQ),
    .IMEM_ADDR       (IMEM_ADDR),
    .IMEM_READY      (IMEM_READY),
    .IMEM_RVALID     (IMEM_RVALID),
    .IMEM_RDATA      (IMEM_RDATA),
    .PC_OUT          (PC_OUT),
    .INSTRUCTION_OUT (INSTRUCTION_OUT),
    .VALID_OUT       (VALID_OUT),
    .FLUSH_OUT       (FLUSH_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------
  // Model: tracks whether a request is outstanding (and whether a redirect
  // has orphaned it), whether a response is being held for decode, the
  // address the next fetch must use, and the last delivered instruction.
  // ---------------------------------------------------------------
  bit          m_init = 1'b0;
  bit          m_out, m_killed, m_held;
  logic [31:0] m_fetch_pc, m_req_pc, m_held_pc, m_held_data;
  logic [31:0] m_pc_out, m_instr;
  logic        m_valid;

  always @(negedge clk) begin : model
    logic e_req;
    e_req = !rst && !REDIRECT && !m_out && !m_held;
    if (m_init) begin
      chkb("mdl_req",   IMEM_REQ,  e_req);
      chk ("mdl_addr",  IMEM_ADDR, m_fetch_pc);
      chkb("mdl_flush", FLUSH_OUT, REDIRECT && !rst);
      chkb("mdl_valid", VALID_OUT, m_valid);
      chk ("mdl_pcout", PC_OUT,    m_pc_out);
      chk ("mdl_instr", INSTRUCTION_OUT, m_instr);
    end
    m_valid = 1'b0;
    if (rst) begin
      m_init     = 1'b1;
      m_out      = 1'b0;
      m_killed   = 1'b0;
      m_held     = 1'b0;
      m_fetch_pc = 32'h0;
      m_pc_out   = 32'h0;
      m_instr    = 32'h0;
    end else if (REDIRECT) begin
      m_fetch_pc = REDIRECT_PC;
      m_held     = 1'b0;
      m_pc_out   = 32'h0;
      m_instr    = 32'h0;
      if (m_out && IMEM_RVALID) m_out = 1'b0;
      else if (m_out)           m_killed = 1'b1;
    end else if (e_req && IMEM_READY) begin
      m_out    = 1'b1;
      m_killed = 1'b0;
      m_req_pc = m_fetch_pc;
    end else if (m_out && IMEM_RVALID) begin
      m_out = 1'b0;
      if (!m_killed) begin
        if (STALL) begin
          m_held      = 1'b1;
          m_held_pc   = m_req_pc;
          m_held_data = IMEM_RDATA;
        end else begin
          m_valid    = 1'b1;
          m_pc_out   = m_req_pc;
          m_instr    = IMEM_RDATA;
          m_fetch_pc = m_req_pc + 32'd4;
        end
      end
      m_killed = 1'b0;
    end else if (m_held && !STALL) begin
      m_held     = 1'b0;
      m_valid    = 1'b1;
      m_pc_out   = m_held_pc;
      m_instr    = m_held_data;
      m_fetch_pc = m_held_pc + 32'd4;
    end
  end

  // Set all inputs for the coming cycle, then let combinational outputs settle.
  task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] rp,
                       input logic rdy, input logic rv, input logic [31:0] dat);
    rst = r; STALL = st; REDIRECT = rd; REDIRECT_PC = rp;
    IMEM_READY = rdy; IMEM_RVALID = rv; IMEM_RDATA = dat;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for three cycles; no request while rst is high.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
      chkb("rst_req", IMEM_REQ, 1'b0);
      chkb("rst_flush", FLUSH_OUT, 1'b0);
      tick();
    end
    chkb("rst_valid", VALID_OUT, 1'b0);
    chk ("rst_pcout", PC_OUT, 32'h0);
    chk ("rst_instr", INSTRUCTION_OUT, 32'h0);

    // First fetch at 0, response 0x13 one cycle after accept.
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    chkb("f0_req", IMEM_REQ, 1'b1);
    chk ("f0_addr", IMEM_ADDR, 32'h0);
    tick();
    drive(0, 0, 0, 32'h0, 0, 1, 32'h0000_0013);
    chkb("f0_wait_req", IMEM_REQ, 1'b0);
    tick();

    // Memory not ready for five cycles: request held at 0x4.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
      if (i == 0) begin
        chkb("d0_valid", VALID_OUT, 1'b1);
        chk ("d0_pcout", PC_OUT, 32'h0);
        chk ("d0_instr", INSTRUCTION_OUT, 32'h0000_0013);
      end else begin
        chkb("nr_valid", VALID_OUT, 1'b0);
      end
      chkb("nr_req", IMEM_REQ, 1'b1);
      chk ("nr_addr", IMEM_ADDR, 32'h4);
      tick();
    end

    // Fetch 0x4 and deliver it.
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    tick();
    drive(0, 0, 0, 32'h0, 0, 1, 32'h1111_1111);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    chkb("d4_valid", VALID_OUT, 1'b1);
    chk ("d4_pcout", PC_OUT, 32'h4);
    chk ("f8_addr", IMEM_ADDR, 32'h8);
    tick();

    // Response for 0x8 arrives under stall: held, no request meanwhile.
    drive(0, 1, 0, 32'h0, 0, 1, 32'hAAAA_AAAA);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 32'h0, 1, 0, 32'h0);
      chkb("hold_valid", VALID_OUT, 1'b0);
      chkb("hold_req", IMEM_REQ, 1'b0);
      tick();
    end
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    chkb("d8_valid", VALID_OUT, 1'b1);
    chk ("d8_pcout", PC_OUT, 32'h8);
    chk ("d8_instr", INSTRUCTION_OUT, 32'hAAAA_AAAA);
    chkb("fC_req", IMEM_REQ, 1'b1);
    chk ("fC_addr", IMEM_ADDR, 32'hC);
    tick();

    // Redirect to 0x100 while waiting; stale response arrives two cycles later.
    drive(0, 0, 1, 32'h100, 0, 0, 32'h0);
    chkb("r100_flush", FLUSH_OUT, 1'b1);
    chkb("r100_req", IMEM_REQ, 1'b0);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    chkb("drop_valid", VALID_OUT, 1'b0);
    chk ("drop_pcout", PC_OUT, 32'h0);
    chk ("drop_instr", INSTRUCTION_OUT, 32'h0);
    chkb("drop_req", IMEM_REQ, 1'b0);
    tick();
    drive(0, 0, 0, 32'h0, 0, 1, 32'hBBBB_BBBB);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    chkb("r100_valid", VALID_OUT, 1'b0);
    chkb("r100_req2", IMEM_REQ, 1'b1);
    chk ("r100_addr", IMEM_ADDR, 32'h100);
    tick();

    // Redirect to 0x40 in the same cycle as the response.
    drive(0, 0, 1, 32'h40, 0, 1, 32'hCCCC_CCCC);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    chkb("r40_valid", VALID_OUT, 1'b0);
    chkb("r40_req", IMEM_REQ, 1'b1);
    chk ("r40_addr", IMEM_ADDR, 32'h40);
    tick();

    // Two redirects while draining, last to 0xFFFFFFFC.
    drive(0, 0, 1, 32'h200, 0, 0, 32'h0);
    tick();
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
    chkb("dd_req", IMEM_REQ, 1'b0);
    tick();
    drive(0, 0, 0, 32'h0, 0, 1, 32'hDDDD_DDDD);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    chk ("wrap_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0, 32'h0, 1, 1, 32'h1234_5678);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    chkb("wrap_valid", VALID_OUT, 1'b1);
    chk ("wrap_pcout", PC_OUT, 32'hFFFF_FFFC);
    chk ("wrap_instr", INSTRUCTION_OUT, 32'h1234_5678);
    chk ("wrap_next", IMEM_ADDR, 32'h0);
    tick();

    // Response held under stall, then redirect discards it; stall keeps
    // prefetching allowed in FETCH.
    drive(0, 1, 0, 32'h0, 0, 1, 32'h5555_5555);
    tick();
    drive(0, 1, 1, 32'h80, 0, 0, 32'h0);
    chkb("rh_flush", FLUSH_OUT, 1'b1);
    tick();
    drive(0, 1, 0, 32'h0, 1, 0, 32'h0);
    chkb("rh_req", IMEM_REQ, 1'b1);
    chk ("rh_addr", IMEM_ADDR, 32'h80);
    chkb("rh_valid", VALID_OUT, 1'b0);
    tick();
    drive(0, 0, 0, 32'h0, 0, 1, 32'h6666_6666);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    chkb("d80_valid", VALID_OUT, 1'b1);
    chk ("d80_pcout", PC_OUT, 32'h80);
    chk ("d80_instr", INSTRUCTION_OUT, 32'h6666_6666);
    tick();

    // Reset while a request is outstanding.
    drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
    chkb("mr_req", IMEM_REQ, 1'b0);
    tick();
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    chkb("mr_req2", IMEM_REQ, 1'b1);
    chk ("mr_addr", IMEM_ADDR, 32'h0);
    chkb("mr_valid", VALID_OUT, 1'b0);
    chk ("mr_pcout", PC_OUT, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
